// File: rtl/pipelined_alu.sv
// Pipelined integer ALU: evaluation in stage 0, then LATENCY-1 pure delay stages,
// with valid/ready handshakes on both sides and a tag that travels with each operation.
module pipelined_alu #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       opcode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] out_tag,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             err,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam int DW  = WIDTH + TAG_W + 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SHL  = 4'd5,
      OP_SHR  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9,
      OP_MUL  = 4'd10
   } op_t;

   logic [LATENCY-1:0] valid_q;
   logic [DW-1:0]      data_q [LATENCY];
   logic [LATENCY-1:0] free;

   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_err;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;

   assign shamt    = op_b[SHW-1:0];
   assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
   assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

   // The extra top bit of diff_ext is the unsigned borrow (A < B).
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff_ext[WIDTH-1:0];
            alu_c   = diff_ext[WIDTH];
            alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_ext[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SHL:  alu_res = op_a << shamt;
         OP_SHR:  alu_res = op_a >> shamt;
         OP_SRA:  alu_res = $signed(op_a) >>> shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OP_MUL:  alu_res = op_a * op_b;
         default: alu_err = 1'b1;
      endcase
   end

   // A stage can take new content unless it and every stage after it are full and
   // the consumer is stalling; this collapses internal bubbles.
   always_comb begin
      logic full_chain;
      full_chain = !out_ready;
      free       = '0;
      for (int k = LATENCY - 1; k >= 0; k--) begin
         full_chain = full_chain & valid_q[k];
         free[k]    = !full_chain;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         if (free[0]) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
               data_q[0] <= {alu_res, in_tag, (alu_res == '0), alu_c, alu_v, alu_err};
            end
         end
         for (int k = 1; k < LATENCY; k++) begin
            if (free[k]) begin
               valid_q[k] <= valid_q[k-1];
               if (valid_q[k-1]) begin
                  data_q[k] <= data_q[k-1];
               end
            end
         end
      end
   end

   assign in_ready  = free[0];
   assign out_valid = valid_q[LATENCY-1];
   assign busy      = |valid_q;
   assign {result, out_tag, flag_z, flag_c, flag_v, err} = data_q[LATENCY-1];

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed vector table, random traffic against
// an arithmetic reference model, backpressure, and reset-mid-stream sequences.
module tb_pipelined_alu;

   localparam int WIDTH   = 32;
   localparam int LATENCY = 2;
   localparam int TAG_W   = 8;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [3:0]       opcode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [TAG_W-1:0] out_tag;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic             err;
   logic             busy;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [TAG_W-1:0] tag;
      logic             z;
      logic             c;
      logic             v;
      logic             e;
   } exp_t;

   typedef struct packed {
      logic [3:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] res;
      logic             z;
      logic             c;
      logic             v;
      logic             e;
   } vec_t;

   int   checks    = 0;
   int   failures  = 0;
   int   emitCount = 0;
   exp_t expQ[$];
   vec_t vecs[14];

   pipelined_alu #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .opcode(opcode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
      .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .err(err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Reference model: plain wide-integer arithmetic on the opcode rules.
   function automatic exp_t refModel(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
      exp_t             r;
      longint unsigned  ua, ub, full;
      longint           sa, sb, sfull, maxS, minS;
      int               sh;
      r     = '0;
      r.tag = tag;
      ua    = a;
      ub    = b;
      sa    = $signed(a);
      sb    = $signed(b);
      sh    = int'(ub % WIDTH);
      maxS  = (longint'(1) <<< (WIDTH - 1)) - 1;
      minS  = -(longint'(1) <<< (WIDTH - 1));
      full  = 0;
      sfull = 0;
      case (op)
         4'd0: begin
            full  = ua + ub;
            r.c   = (full >> WIDTH) != 0;
            sfull = sa + sb;
            r.v   = (sfull > maxS) || (sfull < minS);
         end
         4'd1: begin
            full  = ua - ub;
            r.c   = ua < ub;
            sfull = sa - sb;
            r.v   = (sfull > maxS) || (sfull < minS);
         end
         4'd2:  full = ua & ub;
         4'd3:  full = ua | ub;
         4'd4:  full = ua ^ ub;
         4'd5:  full = ua << sh;
         4'd6:  full = ua >> sh;
         4'd7:  full = longint'(sa >>> sh);
         4'd8:  full = (sa < sb) ? 1 : 0;
         4'd9:  full = (ua < ub) ? 1 : 0;
         4'd10: full = ua * ub;
         default: r.e = 1'b1;
      endcase
      r.res = full[WIDTH-1:0];
      r.z   = (r.res == '0);
      return r;
   endfunction

   // Scoreboard: handshakes sampled mid-cycle take effect at the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         expQ.delete();
      end else begin
         if (out_valid && out_ready) begin
            emitCount++;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_response", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("sb_response", {result, out_tag, flag_z, flag_c, flag_v, err}, e);
            end
         end
         if (in_valid && in_ready) begin
            expQ.push_back(refModel(opcode, op_a, op_b, in_tag));
         end
      end
   end

   task automatic applyStimulus(input vec_t v, output int lat);
      int tries;
      bit acc;
      op_a      = v.a;
      op_b      = v.b;
      opcode    = v.op;
      in_tag    = v.tag;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      acc       = 1'b0;
      tries     = 0;
      while (!acc && tries < 20) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         tries++;
      end
      in_valid = 1'b0;
      checkOutput("accept", acc, 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain();
      int n;
      n         = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((expQ.size() != 0 || busy) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain_complete", (expQ.size() == 0 && !busy), 1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   lat;
      int   i;
      int   cyc;
      int   accCnt;
      int   emitStart;
      bit   acc;
      logic [3:0] pat;
      logic [63:0] held;
      vec_t mulVec;

      vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'd1,        8'h01, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{4'd0,  32'h7FFFFFFF, 32'd1,        8'h02, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{4'd1,  32'd3,        32'd5,        8'h03, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{4'd1,  32'h80000000, 32'd1,        8'h04, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{4'd8,  32'hFFFFFFFF, 32'd1,        8'h05, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'd9,  32'hFFFFFFFF, 32'd1,        8'h06, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{4'd7,  32'h80000000, 32'd4,        8'h07, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{4'd5,  32'd1,        32'h21,       8'h08, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{4'd6,  32'h80000000, 32'h40,       8'h09, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{4'd2,  32'hF0F0,     32'hFF00,     8'h0A, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{4'd3,  32'hF0F0,     32'hFF00,     8'h0B, 32'h0000FFF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{4'd4,  32'hF0F0,     32'hFF00,     8'h0C, 32'h00000FF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{4'd10, 32'h12345,    32'h10,       8'h0D, 32'h00123450, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{4'd12, 32'h1234,     32'h5678,     8'h5A, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
      mulVec   = '{4'd10, 32'h10000,    32'h10000,    8'h77, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset held for two edges with a request pending.
      reset     = 1'b0;
      in_valid  = 1'b1;
      op_a      = 32'd7;
      op_b      = 32'd9;
      opcode    = 4'd0;
      in_tag    = 8'h33;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_data", {result, out_tag, flag_z, flag_c, flag_v, err}, 0);
      @(posedge clk); #1;
      checkOutput("reset_out_valid_2", out_valid, 0);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_after_reset", in_ready, 1);
      @(posedge clk); #1;

      // Directed vector table.
      for (int k = 0; k < 14; k++) begin
         applyStimulus(vecs[k], lat);
         checkOutput($sformatf("v%0d_latency", k), lat, LATENCY - 1);
         checkOutput($sformatf("v%0d_result", k), result, vecs[k].res);
         checkOutput($sformatf("v%0d_tag", k), out_tag, vecs[k].tag);
         checkOutput($sformatf("v%0d_flags_zcve", k), {flag_z, flag_c, flag_v, err},
                     {vecs[k].z, vecs[k].c, vecs[k].v, vecs[k].e});
      end
      drain();

      // Randomized traffic with random backpressure.
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         opcode    = 4'($urandom_range(0, 15));
         op_a      = $urandom;
         op_b      = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 40);
         in_tag    = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      drain();

      // Streaming: 16 ADDs back-to-back while out_ready follows 1,0,0,1.
      pat       = 4'b1001;
      emitStart = emitCount;
      i         = 0;
      cyc       = 0;
      while ((i < 16 || expQ.size() != 0) && cyc < 300) begin
         in_valid  = (i < 16);
         opcode    = 4'd0;
         op_a      = WIDTH'(i);
         op_b      = WIDTH'(i);
         in_tag    = TAG_W'(i);
         out_ready = pat[cyc % 4];
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) i++;
         cyc++;
      end
      checkOutput("stream_response_count", emitCount - emitStart, 16);
      drain();

      // Held backpressure: exactly LATENCY accepts, outputs stable, same-cycle release.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      opcode    = 4'd1;
      accCnt    = 0;
      for (int k = 0; k < 8; k++) begin
         op_a   = WIDTH'(100 + k);
         op_b   = WIDTH'(k);
         in_tag = TAG_W'(8'h80 + k);
         @(negedge clk);
         if (in_valid && in_ready) accCnt++;
         @(posedge clk); #1;
      end
      checkOutput("bp_accept_count", accCnt, LATENCY);
      checkOutput("bp_in_ready_low", in_ready, 0);
      checkOutput("bp_busy", busy, 1);
      held = 64'({result, out_tag, flag_z, flag_c, flag_v, err});
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_output_held", 64'({result, out_tag, flag_z, flag_c, flag_v, err}), held);
      checkOutput("bp_held_tag", out_tag, 8'h80);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      drain();

      // Reset with two operations in flight discards them.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      opcode    = 4'd0;
      op_a      = 32'd1;
      op_b      = 32'd2;
      in_tag    = 8'hE0;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("midreset_inflight_busy", busy, 1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_out_valid", out_valid, 0);
      emitStart = emitCount;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("midreset_no_responses", emitCount - emitStart, 0);
      applyStimulus(mulVec, lat);
      checkOutput("mul_latency", lat, LATENCY - 1);
      checkOutput("mul_result", result, mulVec.res);
      checkOutput("mul_flag_z", flag_z, 1);
      checkOutput("mul_tag", out_tag, mulVec.tag);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised, pipelined successor to `simple_alu`. It performs one integer operation per accepted request, with configurable data width and pipeline depth, valid/ready handshakes on both sides, and a tag that travels with each operation. Result flags and an illegal-opcode error are produced. It sits between the DPI-fed emulation testbench transactor (request side) and the software result collector (response side). It sustains one operation per cycle when the response side is not stalled.

## Interface
- `WIDTH`, 32, operand/result width; must be ≥ 8 and a power of two.
- `LATENCY`, 2, number of pipeline register stages; must be ≥ 1.
- `TAG_W`, 8, width of the opaque tag carried alongside each operation.
- `clk` input 1: clock; all state is updated on the rising edge.
- `reset` input 1: reset, synchronous, active-low; clock `clk`.
- `in_valid` input 1: request present.
- `in_ready` output 1: block accepts the request this cycle.
- `op_a` input WIDTH: operand A.
- `op_b` input WIDTH: operand B.
- `opcode` input 4: operation select.
- `in_tag` input TAG_W: request tag.
- `out_valid` output 1: response present.
- `out_ready` input 1: consumer takes the response this cycle.
- `result` output WIDTH: operation result.
- `out_tag` output TAG_W: tag of the request that produced this response.
- `flag_z` output 1: result == 0.
- `flag_c` output 1: carry/borrow.
- `flag_v` output 1: signed overflow.
- `err` output 1: illegal opcode.
- `busy` output 1: at least one stage holds a valid operation.

## Operation
- **Opcodes:**
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: shift A left by B[log2(WIDTH)-1:0].
  - 6 SHR: logical right shift, same shift amount as SHL.
  - 7 SRA: arithmetic right shift, same shift amount as SHL.
  - 8 SLT: signed A<B gives 1, else 0.
  - 9 SLTU: unsigned compare, same encoding as SLT.
  - 10 MUL: low WIDTH bits of the unsigned product.
  - 11–15 illegal: result = 0, err = 1, flag_z = 1, flag_c = flag_v = 0.
- **Flags:**
  - flag_c: ADD carry-out of bit WIDTH-1. For SUB, flag_c = 1 iff A < B unsigned (borrow). 0 for all other opcodes.
  - flag_v: ADD/SUB signed overflow only. 0 otherwise.
  - flag_z: computed on the final result for every opcode.
- **Pipeline:**
  - Evaluation is performed in the first stage.
  - The remaining LATENCY-1 stages are pure delay, each holding a valid bit plus {result, tag, flags, err}.
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage advances when out_valid && out_ready.
- **Handshakes:**
  - A request is accepted when in_valid && in_ready.
  - in_ready = (stage 0 empty) || (stage 0 advancing). It is combinational from out_ready through the chain; internal bubbles are collapsed.
  - out_valid = valid bit of the last stage. result, out_tag, flags and err are held stable while out_valid && !out_ready.
  - Ordering is strictly FIFO. There are no drops and no duplicates.
- busy = OR of all stage valid bits.

## Timing
- **Reset:**
  - Reset is sampled when reset == 0 at a rising edge. It clears all stage valid bits and zeroes all data registers.
  - After that edge: out_valid = 0, result = 0, out_tag = 0, flags = 0, err = 0, busy = 0.
  - in_ready = 1 from the first cycle after release.
  - Reset asserted mid-operation discards every in-flight operation. No response is emitted for it.
- **Latency:** a request accepted at edge N appears with out_valid = 1 after edge N+LATENCY-1, so it is visible for consumption at edge N+LATENCY, given no stall.
- **Throughput:** back-to-back acceptance every cycle while out_ready = 1.
- **Backpressure:**
  - With out_ready held 0, the pipeline fills.
  - Exactly LATENCY operations are accepted in total. in_ready then drops in the same cycle the last stage is full and nothing can advance.
- **Release:** when out_ready rises with all stages full, in_ready = 1 in that same cycle. Simultaneous accept and emit is legal.
- **Shift amounts:** upper bits of op_b are ignored for shifts. Shift by 0 returns A unchanged.

## Test plan
- **Reset:** hold reset=0 for 2 cycles with in_valid=1, then release. Expect out_valid=0, busy=0, result=0 during reset; in_ready=1 after release.
- **Arithmetic** (WIDTH=32, LATENCY=2):
  - ADD 0xFFFFFFFF+1 gives result 0, flag_z=1, flag_c=1, flag_v=0, visible 2 edges after acceptance.
  - ADD 0x7FFFFFFF+1 gives 0x80000000, flag_v=1.
- **SUB/compare/shift:**
  - SUB 3−5 gives 0xFFFFFFFE, flag_c=1.
  - SLT 0xFFFFFFFF,1 gives 1; SLTU on the same operands gives 0.
  - SRA 0x80000000 by 4 gives 0xF8000000.
  - SHL 1 by 0x21 gives 2.
- **Illegal opcode:** opcode 12 with tag 0x5A gives err=1, result=0, flag_z=1, out_tag=0x5A.
- **Streaming with backpressure:**
  - Send 16 ADDs (A=i, B=i, tag=i) back-to-back while out_ready toggles 1,0,0,1,….
  - Expect results 2i in order with matching tags, no loss.
  - With out_ready=0 held, exactly LATENCY accepts occur.
- **Reset mid-stream:** with 2 operations in flight, pulse reset=0 for 1 cycle. Expect no responses for those operations and busy=0. A following MUL 0x10000×0x10000 returns 0.
